// File: rtl/operand_triple_loader.sv
// operand_triple_loader
//   Assembles a serial operand stream (valid/ready) into an A, B, C triple
//   plus carry-in for the 3-operand adder. The triple is held stable with
//   op_valid high until the consumer accepts it. A partial triple is dropped
//   when the stream stays idle for TIMEOUT cycles in S_B or S_C.
//
//   Optional feature macro: LOADER_CARRY_IN_EN
//     defined   : adds input in_cin, sampled with the C beat, drives C_in
//     undefined : no in_cin port, C_in is constant 0
//
//   Handshake semantics (both interfaces): a transfer happens on a rising
//   clk edge where valid && ready are both high; valid may not depend on
//   ready, and the producer holds data stable while valid && !ready.
module operand_triple_loader #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef LOADER_CARRY_IN_EN
  input  logic             in_cin,
`endif
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic             C_in,
  output logic             op_valid,
  input  logic             op_ready,
  output logic             err_timeout,
  output logic [7:0]       triple_count,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_C    = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] idle_cnt_next;
  logic             accept;
  logic             handshake;
  logic             in_partial;
  logic             idle_expire;
  logic             load_a;
  logic             load_b;
  logic             load_c;
  logic             abort;

  assign dbg_state  = state;
  assign in_ready   = !rst && (state != S_HOLD);
  assign accept     = in_valid && in_ready;
  assign handshake  = op_valid && op_ready;
  assign in_partial = (state == S_B) || (state == S_C);
  // An accept in the expiring cycle wins over the abort.
  assign idle_expire = in_partial && !accept && (idle_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_A;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-edge load/abort strobes
  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_c     = 1'b0;
    abort      = 1'b0;
    case (state)
      S_A: begin
        if (accept) begin
          load_a     = 1'b1;
          state_next = S_B;
        end
      end
      S_B: begin
        if (accept) begin
          load_b     = 1'b1;
          state_next = S_C;
        end else if (idle_expire) begin
          abort      = 1'b1;
          state_next = S_A;
        end
      end
      S_C: begin
        if (accept) begin
          load_c     = 1'b1;
          state_next = S_HOLD;
        end else if (idle_expire) begin
          abort      = 1'b1;
          state_next = S_A;
        end
      end
      S_HOLD: begin
        if (handshake) begin
          state_next = S_A;
        end
      end
      default: state_next = S_A;
    endcase
  end

  // Idle counter: counts only inside a partial triple, clears on any accept
  always_comb begin
    idle_cnt_next = '0;
    if (in_partial && !accept && !idle_expire) begin
      idle_cnt_next = idle_cnt + 1'b1;
    end
  end

  // Idle counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt_next;
    end
  end

  // Operand registers; frozen outside their own load edge
  always_ff @(posedge clk) begin
    if (rst) begin
      A <= '0;
      B <= '0;
      C <= '0;
    end else begin
      if (load_a) A <= in_data;
      if (load_b) B <= in_data;
      if (load_c) C <= in_data;
    end
  end

`ifdef LOADER_CARRY_IN_EN
  // Carry-in captured with the C beat and held through S_HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      C_in <= 1'b0;
    end else if (load_c) begin
      C_in <= in_cin;
    end
  end
`else
  assign C_in = 1'b0;
`endif

  // Triple-valid flag, abort pulse and delivered-triple counter
  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid     <= 1'b0;
      err_timeout  <= 1'b0;
      triple_count <= 8'd0;
    end else begin
      err_timeout <= abort;
      if (load_c) begin
        op_valid <= 1'b1;
      end else if (handshake) begin
        op_valid <= 1'b0;
      end
      if (handshake) begin
        triple_count <= triple_count + 8'd1;
      end
    end
  end

endmodule
